// File: rtl/temporal_buffer_ctrl.sv
// Sequences one flip evaluation through the temporal clause buffer:
// fill all slots, take a slot selection, wait out the read latency, present the slot.
module temporal_buffer_ctrl #(
  parameter int NSAT         = 3,
  parameter int NSAT_BITS    = 2,
  parameter int READ_LATENCY = 1,
  parameter int COUNT_WIDTH  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start_i,
  input  logic                   wr_valid_i,
  output logic                   wr_ready_o,
  output logic                   write_en_o,
  output logic [NSAT_BITS-1:0]   write_index_o,
  output logic                   full_o,
  input  logic                   sel_valid_i,
  input  logic [NSAT_BITS-1:0]   sel_index_i,
  output logic                   sel_ready_o,
  output logic [NSAT_BITS-1:0]   read_index_o,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic                   err_o,
  output logic [COUNT_WIDTH-1:0] batch_count_o
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FILL     = 3'd1,
    WAIT_SEL = 3'd2,
    READ     = 3'd3,
    OUT      = 3'd4
  } state_t;

  localparam int                   EXT_W     = NSAT_BITS + 1;
  localparam logic [NSAT_BITS-1:0] LAST_SLOT = NSAT_BITS'(NSAT - 1);
  localparam logic [EXT_W-1:0]     NSAT_EXT  = EXT_W'(NSAT);
  localparam logic [2:0]           LAT_INIT  = 3'(READ_LATENCY);

  state_t                 state_r;
  state_t                 next_state_s;
  logic [NSAT_BITS-1:0]   wr_ptr_r;
  logic [NSAT_BITS-1:0]   read_index_r;
  logic [2:0]             lat_cnt_r;
  logic                   err_r;
  logic [COUNT_WIDTH-1:0] batch_count_r;

  logic write_fire_s;
  logic sel_fire_s;
  logic sel_ok_s;
  logic out_fire_s;

  // A coincident start_i wins over every handshake, so each fire is gated by it.
  assign write_fire_s = (state_r == FILL) && wr_valid_i && !start_i;
  assign sel_fire_s   = (state_r == WAIT_SEL) && sel_valid_i && !start_i;
  assign out_fire_s   = (state_r == OUT) && out_ready_i && !start_i;
  assign sel_ok_s     = ({1'b0, sel_index_i} < NSAT_EXT);

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode
  always_comb begin
    next_state_s = state_r;
    if (start_i) begin
      next_state_s = FILL;
    end else begin
      case (state_r)
        IDLE:     next_state_s = IDLE;
        FILL: begin
          if (wr_valid_i && (wr_ptr_r == LAST_SLOT)) next_state_s = WAIT_SEL;
          else                                       next_state_s = FILL;
        end
        WAIT_SEL: begin
          if (sel_valid_i && sel_ok_s) next_state_s = READ;
          else                         next_state_s = WAIT_SEL;
        end
        READ: begin
          if (lat_cnt_r <= 3'd1) next_state_s = OUT;
          else                   next_state_s = READ;
        end
        OUT: begin
          if (out_ready_i) next_state_s = FILL;
          else             next_state_s = OUT;
        end
        default:  next_state_s = IDLE;
      endcase
    end
  end

  // Slot pointer, read index, latency counter, sticky error and batch counter
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_r      <= {NSAT_BITS{1'b0}};
      read_index_r  <= {NSAT_BITS{1'b0}};
      lat_cnt_r     <= 3'd0;
      err_r         <= 1'b0;
      batch_count_r <= {COUNT_WIDTH{1'b0}};
    end else begin
      if (start_i || out_fire_s) begin
        wr_ptr_r <= {NSAT_BITS{1'b0}};
      end else if (write_fire_s) begin
        wr_ptr_r <= (wr_ptr_r == LAST_SLOT) ? {NSAT_BITS{1'b0}} : wr_ptr_r + NSAT_BITS'(1);
      end

      if (sel_fire_s && sel_ok_s) begin
        read_index_r <= sel_index_i;
        lat_cnt_r    <= LAT_INIT;
      end else if ((state_r == READ) && (lat_cnt_r != 3'd0)) begin
        lat_cnt_r <= lat_cnt_r - 3'd1;
      end

      if (sel_fire_s && !sel_ok_s) begin
        err_r <= 1'b1;
      end

      if (out_fire_s) begin
        batch_count_r <= batch_count_r + COUNT_WIDTH'(1);
      end
    end
  end

  // Handshake outputs decoded from the registered state
  always_comb begin
    wr_ready_o    = 1'b0;
    full_o        = 1'b0;
    sel_ready_o   = 1'b0;
    out_valid_o   = 1'b0;
    write_index_o = {NSAT_BITS{1'b0}};
    case (state_r)
      FILL: begin
        wr_ready_o    = 1'b1;
        write_index_o = wr_ptr_r;
      end
      WAIT_SEL: begin
        full_o      = 1'b1;
        sel_ready_o = 1'b1;
      end
      OUT:     out_valid_o = 1'b1;
      default: wr_ready_o  = 1'b0;
    endcase
    write_en_o = wr_valid_i && wr_ready_o;
  end

  assign read_index_o  = read_index_r;
  assign err_o         = err_r;
  assign batch_count_o = batch_count_r;

endmodule
